// File: rtl/regfile_pkg.sv
// Shared widths, the zero-register address and the read-bus field extractor
// for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int MAX_ADDR_W = 16;
    localparam int MAX_RD     = 4;
    localparam int RD_BUS_W   = MAX_RD * MAX_ADDR_W;

    localparam int unsigned ZERO_ADDR = 0;

    // Field k of width w from a packed bus, zero-extended into 32 bits.
    function automatic logic [31:0] port_field(input logic [RD_BUS_W-1:0] bus,
                                               input int unsigned k,
                                               input int unsigned w);
        logic [RD_BUS_W-1:0] sh;
        sh = bus >> (k * w);
        return 32'(sh) & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: alloc sets, writeback clears, alloc wins on a tie.
// Also provides the per-read-port busy lookup and a registered any_busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic                     clr0_en,
    input  logic [ADDR_W-1:0]        clr0_addr,
    input  logic                     clr1_en,
    input  logic [ADDR_W-1:0]        clr1_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     any_busy
);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic             any_busy_q, any_busy_d;
    logic             alloc_act;

    assign alloc_act = alloc_en &&
                       !((ZERO_REG != 0) && (alloc_addr == ADDR_W'(ZERO_ADDR)));

    always_comb begin
        busy_d = busy_q;
        if (clr0_en) busy_d[clr0_addr] = 1'b0;
        if (clr1_en) busy_d[clr1_addr] = 1'b0;
        // Applied last so a same-cycle allocation survives the writeback clear.
        if (alloc_act) busy_d[alloc_addr] = 1'b1;
        any_busy_d = |busy_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            any_busy_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            any_busy_q <= any_busy_d;
        end
    end

    assign any_busy = any_busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              wr_hit;
        logic              is_zero;

        assign ra      = ADDR_W'(port_field(RD_BUS_W'(rd_addr), k, ADDR_W));
        assign is_zero = (ZERO_REG != 0) && (ra == ADDR_W'(ZERO_ADDR));
        // A writeback in flight releases the register early unless it is re-allocated now.
        assign wr_hit  = (BYPASS != 0) &&
                         ((clr0_en && clr0_addr == ra) || (clr1_en && clr1_addr == ra)) &&
                         !(alloc_en && alloc_addr == ra);
        assign rd_busy[k] = busy_q[ra] && !wr_hit && !is_zero;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised write
// ports, optional write-to-read bypass, optional hardwired zero register.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic                     any_busy
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic                         wr0_act, wr1_act;

    // Writes are squashed under reset so nothing is bypassed or cleared then.
    assign wr0_act = we0 && !rst &&
                     !((ZERO_REG != 0) && (waddr0 == ADDR_W'(ZERO_ADDR)));
    assign wr1_act = we1 && !rst &&
                     !((ZERO_REG != 0) && (waddr1 == ADDR_W'(ZERO_ADDR)));

    always_comb begin
        mem_d = mem_q;
        if (wr0_act) mem_d[waddr0] = wdata0;
        if (wr1_act) mem_d[waddr1] = wdata1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = ADDR_W'(port_field(RD_BUS_W'(rd_addr), k, ADDR_W));

        always_comb begin
            rv = mem_q[ra];
            if (BYPASS != 0) begin
                if (wr1_act && waddr1 == ra)      rv = wdata1;
                else if (wr0_act && waddr0 == ra) rv = wdata0;
            end
            if ((ZERO_REG != 0) && (ra == ADDR_W'(ZERO_ADDR))) rv = '0;
        end

        assign rd_data[k*DATA_W +: DATA_W] = rv;
    end

    regfile_scoreboard #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .BYPASS  (BYPASS),
        .ZERO_REG(ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .alloc_en  (alloc_en && !rst),
        .alloc_addr(alloc_addr),
        .clr0_en   (wr0_act),
        .clr0_addr (waddr0),
        .clr1_en   (wr1_act),
        .clr1_addr (waddr1),
        .rd_busy   (rd_busy),
        .any_busy  (any_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing and a non-bypassing instance share one
// stimulus stream and are compared to an array-based reference model.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 32;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0]    ra [NR];
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rdd_a, rdd_b;
    logic [NR-1:0]    rdb_a, rdb_b;
    logic             anyb_a, anyb_b;
    logic             we0, we1, alloc_en;
    logic [AW-1:0]    waddr0, waddr1, alloc_addr;
    logic [DW-1:0]    wdata0, wdata1;

    assign rd_addr = {ra[3], ra[2], ra[1], ra[0]};

    regfile_mp #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)) u_byp (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdd_a), .rd_busy(rdb_a),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .any_busy(anyb_a));

    regfile_mp #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .ZERO_REG(1)) u_nobyp (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdd_b), .rd_busy(rdb_b),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .any_busy(anyb_b));

    // Reference model state
    logic [DW-1:0] m_mem [D];
    bit            m_busy [D];
    int            n_chk = 0;
    int            n_pass = 0;

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (rst || a == 0) return '0;
        if (byp && we1 && waddr1 == a) return wdata1;
        if (byp && we0 && waddr0 == a) return wdata0;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
        if (rst || a == 0) return 1'b0;
        if (byp && ((we1 && waddr1 == a) || (we0 && waddr0 == a)) &&
            !(alloc_en && alloc_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit exp_any();
        for (int i = 0; i < D; i++) if (m_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; alloc_en = 1'b0;
        waddr0 = '0; waddr1 = '0; alloc_addr = '0;
        wdata0 = '0; wdata1 = '0;
    endtask

    // One clock edge; the model commits whatever the inputs request.
    task automatic tick();
        @(posedge clk);
        if (rst) model_clear();
        else begin
            if (we0 && waddr0 != 0) m_mem[waddr0] = wdata0;
            if (we1 && waddr1 != 0) m_mem[waddr1] = wdata1;
            if (we0) m_busy[waddr0] = 1'b0;
            if (we1) m_busy[waddr1] = 1'b0;
            if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); model_clear();
        for (int k = 0; k < NR; k++) ra[k] = AW'(k + 4);
        #1;
        n_chk++; if (rdd_a !== '0) $display("FAIL reset_rd_data_byp: got %h want 0", rdd_a); else n_pass++;
        n_chk++; if (rdd_b !== '0) $display("FAIL reset_rd_data_nobyp: got %h want 0", rdd_b); else n_pass++;
        n_chk++; if (rdb_a !== '0 || rdb_b !== '0) $display("FAIL reset_rd_busy: got %b/%b want 0", rdb_a, rdb_b); else n_pass++;
        n_chk++; if (anyb_a !== 1'b0 || anyb_b !== 1'b0) $display("FAIL reset_any_busy: got %b/%b want 0", anyb_a, anyb_b); else n_pass++;
        #2 rst = 1'b0;
        tick();
        we0 = 1'b1; waddr0 = 5; wdata0 = 32'hDEADBEEF; alloc_en = 1'b1; alloc_addr = 6;
        tick();
        idle(); ra[0] = 5;
        #1;
        n_chk++; if (rdd_a[31:0] !== 32'hDEADBEEF) $display("FAIL preload_r5: got %h want deadbeef", rdd_a[31:0]); else n_pass++;
        n_chk++; if (anyb_a !== 1'b1) $display("FAIL preload_any_busy: got %b want 1", anyb_a); else n_pass++;
        #1 rst = 1'b1; model_clear();
        #1;
        n_chk++; if (rdd_a[31:0] !== '0 || rdd_b[31:0] !== '0) $display("FAIL async_reset_r5: got %h/%h want 0", rdd_a[31:0], rdd_b[31:0]); else n_pass++;
        n_chk++; if (anyb_a !== 1'b0 || anyb_b !== 1'b0) $display("FAIL async_reset_any_busy: got %b/%b want 0", anyb_a, anyb_b); else n_pass++;
        we0 = 1'b1; waddr0 = 5; wdata0 = 32'h1; alloc_en = 1'b1; alloc_addr = 5;
        #1;
        n_chk++; if (rdd_a[31:0] !== '0) $display("FAIL reset_no_bypass: got %h want 0", rdd_a[31:0]); else n_pass++;
        tick();
        idle(); rst = 1'b0;
        #1;
        n_chk++; if (rdd_a[31:0] !== '0 || rdd_b[31:0] !== '0) $display("FAIL reset_drops_write: got %h/%h want 0", rdd_a[31:0], rdd_b[31:0]); else n_pass++;
        n_chk++; if (anyb_a !== 1'b0 || rdb_a[0] !== 1'b0) $display("FAIL reset_drops_alloc: got %b/%b want 0", anyb_a, rdb_a[0]); else n_pass++;
    endtask

    task automatic test_write_conflict();
        idle(); ra[0] = 7;
        we0 = 1'b1; we1 = 1'b1; waddr0 = 7; waddr1 = 7; wdata0 = 32'h11; wdata1 = 32'h22;
        #1;
        n_chk++; if (rdd_a[31:0] !== 32'h22) $display("FAIL conflict_bypass: got %h want 22", rdd_a[31:0]); else n_pass++;
        n_chk++; if (rdd_b[31:0] !== 32'h0) $display("FAIL conflict_old_value: got %h want 0", rdd_b[31:0]); else n_pass++;
        tick(); idle();
        #1;
        n_chk++; if (rdd_a[31:0] !== 32'h22 || rdd_b[31:0] !== 32'h22) $display("FAIL conflict_stored: got %h/%h want 22", rdd_a[31:0], rdd_b[31:0]); else n_pass++;
    endtask

    task automatic test_bypass();
        idle(); ra[1] = 3;
        we0 = 1'b1; waddr0 = 3; wdata0 = 32'hA5A5A5A5;
        #1;
        n_chk++; if (rdd_a[63:32] !== 32'hA5A5A5A5) $display("FAIL bypass_on: got %h want a5a5a5a5", rdd_a[63:32]); else n_pass++;
        n_chk++; if (rdd_b[63:32] !== 32'h0) $display("FAIL bypass_off_same_cycle: got %h want 0", rdd_b[63:32]); else n_pass++;
        tick(); idle();
        #1;
        n_chk++; if (rdd_b[63:32] !== 32'hA5A5A5A5) $display("FAIL bypass_off_next_cycle: got %h want a5a5a5a5", rdd_b[63:32]); else n_pass++;
    endtask

    task automatic test_zero_reg();
        idle(); ra[2] = 0;
        we1 = 1'b1; waddr1 = 0; wdata1 = 32'hFFFFFFFF; alloc_en = 1'b1; alloc_addr = 0;
        #1;
        n_chk++; if (rdd_a[95:64] !== '0 || rdb_a[2] !== 1'b0) $display("FAIL zero_same_cycle: got %h/%b want 0/0", rdd_a[95:64], rdb_a[2]); else n_pass++;
        tick(); idle();
        #1;
        n_chk++; if (rdd_a[95:64] !== '0 || rdd_b[95:64] !== '0) $display("FAIL zero_stored: got %h/%h want 0", rdd_a[95:64], rdd_b[95:64]); else n_pass++;
        n_chk++; if (rdb_a[2] !== 1'b0 || anyb_a !== 1'b0 || anyb_b !== 1'b0) $display("FAIL zero_busy: got %b/%b/%b want 0", rdb_a[2], anyb_a, anyb_b); else n_pass++;
    endtask

    task automatic test_scoreboard();
        idle(); ra[3] = 9;
        alloc_en = 1'b1; alloc_addr = 9;
        tick(); idle();
        #1;
        n_chk++; if (rdb_a[3] !== 1'b1 || rdb_b[3] !== 1'b1 || anyb_a !== 1'b1) $display("FAIL sb_alloc: got %b/%b/%b want 1", rdb_a[3], rdb_b[3], anyb_a); else n_pass++;
        we0 = 1'b1; waddr0 = 9; wdata0 = 32'h1234; alloc_en = 1'b1; alloc_addr = 9;
        #1;
        n_chk++; if (rdb_a[3] !== 1'b1) $display("FAIL sb_realloc_same_cycle: got %b want 1", rdb_a[3]); else n_pass++;
        tick(); idle();
        #1;
        n_chk++; if (rdb_a[3] !== 1'b1 || rdd_a[127:96] !== 32'h1234) $display("FAIL sb_alloc_wins: got %b/%h want 1/1234", rdb_a[3], rdd_a[127:96]); else n_pass++;
        we1 = 1'b1; waddr1 = 9; wdata1 = 32'h1234;
        #1;
        n_chk++; if (rdb_a[3] !== 1'b0 || rdb_b[3] !== 1'b1) $display("FAIL sb_release_bypass: got %b/%b want 0/1", rdb_a[3], rdb_b[3]); else n_pass++;
        tick(); idle();
        #1;
        n_chk++; if (rdb_a[3] !== 1'b0 || rdb_b[3] !== 1'b0 || anyb_a !== 1'b0 || anyb_b !== 1'b0) $display("FAIL sb_release: got %b/%b/%b/%b want 0", rdb_a[3], rdb_b[3], anyb_a, anyb_b); else n_pass++;
    endtask

    task automatic test_four_ports();
        logic [DW-1:0] want [NR];
        logic [AW-1:0] adr  [NR];
        adr  = '{5'd1, 5'd2, 5'd3, 5'd31};
        want = '{32'h1, 32'h2, 32'h3, 32'h1F};
        idle();
        we0 = 1'b1; waddr0 = 1; wdata0 = 32'h1; we1 = 1'b1; waddr1 = 2; wdata1 = 32'h2;
        tick();
        waddr0 = 3; wdata0 = 32'h3; waddr1 = 31; wdata1 = 32'h1F;
        tick(); idle();
        for (int k = 0; k < NR; k++) ra[k] = adr[k];
        #1;
        for (int k = 0; k < NR; k++) begin
            n_chk++;
            if (rdd_a[k*DW +: DW] !== want[k] || rdd_b[k*DW +: DW] !== want[k])
                $display("FAIL four_ports p%0d: got %h/%h want %h", k, rdd_a[k*DW +: DW], rdd_b[k*DW +: DW], want[k]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we0 = 1'($urandom); we1 = 1'($urandom); alloc_en = 1'($urandom);
            waddr0 = rand_addr(); waddr1 = rand_addr(); alloc_addr = rand_addr();
            wdata0 = $urandom; wdata1 = $urandom;
            for (int k = 0; k < NR; k++) ra[k] = rand_addr();
            #1;
            for (int k = 0; k < NR; k++) begin
                n_chk++;
                if (rdd_a[k*DW +: DW] !== exp_rd(ra[k], 1'b1))
                    $display("FAIL rand_rd_byp c%0d p%0d: got %h want %h", c, k, rdd_a[k*DW +: DW], exp_rd(ra[k], 1'b1));
                else n_pass++;
                n_chk++;
                if (rdd_b[k*DW +: DW] !== exp_rd(ra[k], 1'b0))
                    $display("FAIL rand_rd_nobyp c%0d p%0d: got %h want %h", c, k, rdd_b[k*DW +: DW], exp_rd(ra[k], 1'b0));
                else n_pass++;
                n_chk++;
                if (rdb_a[k] !== exp_busy(ra[k], 1'b1) || rdb_b[k] !== exp_busy(ra[k], 1'b0))
                    $display("FAIL rand_busy c%0d p%0d: got %b/%b want %b/%b", c, k, rdb_a[k], rdb_b[k],
                             exp_busy(ra[k], 1'b1), exp_busy(ra[k], 1'b0));
                else n_pass++;
            end
            tick();
            n_chk++;
            if (anyb_a !== exp_any() || anyb_b !== exp_any())
                $display("FAIL rand_any_busy c%0d: got %b/%b want %b", c, anyb_a, anyb_b, exp_any());
            else n_pass++;
        end
        idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_conflict();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_four_ports();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the next-generation datapath.
- Supports NUM_RD combinational read ports and two synchronous write ports with a fixed priority.
- Optional write-to-read bypass; optional hardwired zero register.
- Per-register busy scoreboard: issue logic allocates a destination, writeback releases it.

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers; power of two, at least 2
- ADDR_W, 5, address width; must equal log2(DEPTH)
- NUM_RD, 2, number of read ports, 1 to 4
- BYPASS, 1, 1 = write data of the current cycle forwarded to matching reads
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high; clears all registers and busy bits
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, same packing as rd_addr
- rd_busy  out  NUM_RD  scoreboard busy bit of each addressed register
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1; port 1 has priority over port 0
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- alloc_en  in  1  mark alloc_addr busy
- alloc_addr  in  ADDR_W  register to allocate
- any_busy  out  1  OR of all busy bits

Behaviour:
- Storage: DEPTH x DATA_W array plus DEPTH busy bits, all updated on the rising clk edge.
- Reset: rst high clears every register to 0 and every busy bit to 0, immediately and without waiting for clk.
  - Reset outputs: rd_data all 0, rd_busy all 0, any_busy 0.
  - Reset asserted mid-operation discards any write or alloc in that cycle.
- Write:
  - weN high commits wdataN to waddrN at the next edge.
  - we0 and we1 to the same address in one cycle: wdata1 is stored and wdata0 is dropped.
  - ZERO_REG=1: writes to address 0 are ignored.
- Read: rd_data[k] = reg[rd_addr[k]], combinational, zero latency.
- Bypass (BYPASS=1):
  - If we1 is high and waddr1 == rd_addr[k], rd_data[k] = wdata1.
  - Otherwise, if we0 is high and waddr0 == rd_addr[k], rd_data[k] = wdata0.
  - Otherwise rd_data[k] is the stored value.
  - Never bypass onto address 0 when ZERO_REG=1.
- No bypass (BYPASS=0): a read returns the pre-edge value; a new value is visible one cycle after the write.
- ZERO_REG=1: reads of address 0 always return 0 and rd_busy 0.
- Scoreboard:
  - alloc_en sets busy[alloc_addr] at the next edge.
  - A write on either port clears busy[waddr] at the next edge.
  - Alloc and write to the same address in the same cycle: busy ends up set (the new allocation wins); the data is still written.
  - alloc_en to a register that is already busy: busy stays set, no error.
  - ZERO_REG=1: alloc to address 0 is ignored.
- rd_busy[k]:
  - Equals busy[rd_addr[k]].
  - With BYPASS=1, rd_busy[k] is 0 when a same-cycle write matches rd_addr[k] and no same-cycle alloc targets that address.
- any_busy: registered view of the OR of all busy bits; reflects the state after the last edge.
- Out-of-range: DEPTH == 2**ADDR_W, so every address is valid.

Decomposition:
- Package regfile_pkg holds:
  - the address and data width localparams;
  - a helper function that extracts read port k from the packed buses;
  - the ZERO_ADDR constant.
- Sub-module regfile_scoreboard: busy-bit array with its alloc/clear priority logic, any_busy and busy lookup.
- Data array, write priority and bypass muxes stay in the top level.

Test Plan:
- Reset check: write 0xDEADBEEF to r5, then pulse rst between edges -> rd_data for r5 is 0 immediately and any_busy is 0.
- Write conflict: we0=we1=1, waddr0=waddr1=7, wdata0=0x11, wdata1=0x22 -> r7 reads 0x22 next cycle; with BYPASS=1 it reads 0x22 in the same cycle.
- Bypass on/off:
  - BYPASS=1: write 0xA5A5A5A5 to r3 while reading r3 -> same-cycle rd_data = 0xA5A5A5A5.
  - BYPASS=0: same stimulus -> same-cycle rd_data is the old value, new value one cycle later.
- Zero register: write 0xFFFFFFFF to r0 and alloc r0 -> r0 reads 0, rd_busy 0, any_busy 0.
- Scoreboard: alloc r9 -> rd_busy=1 next cycle; write r9 = 0x1234 with simultaneous alloc r9 -> busy stays 1 and data is 0x1234; write r9 alone -> busy 0, any_busy 0.
- NUM_RD=4 with four distinct addresses (1, 2, 3, 31) preloaded with 0x1, 0x2, 0x3, 0x1F -> all four ports return correct values in the same cycle.
